fifo_kband_sc: RTL and testbench

- Single-clock, parametrised successor of the K-band input FIFO that buffers encoded sequence symbols (default 3-bit) ahead of the systolic K-band array.
- Generalised in width and depth.
- Adds selectable show-ahead or normal read mode, occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags for debug readback.

---
 rtl/fifo_kband_sc.sv | 107 ++++++++++
 tb/tb_fifo_kband_sc.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_kband_sc.sv
// Single-clock symbol FIFO feeding the K-band systolic array.
// Show-ahead or normal read mode, occupancy flags, flush, and sticky error flags.
module fifo_kband_sc #(
   parameter int unsigned DATA_WIDTH = 3,
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned SHOWAHEAD  = 1,
   parameter int unsigned AF_LEVEL   = (1 << DEPTH_LOG2) - 2,
   parameter int unsigned AE_LEVEL   = 2
) (
   input  logic                  clock,
   input  logic                  aclr,
   input  logic                  sclr,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  wrreq,
   input  logic                  rdreq,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   usedw,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned UW    = DEPTH_LOG2 + 1;
   localparam int unsigned PW    = DEPTH_LOG2;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic [PW-1:0]         wr_ptr_nxt, rd_ptr_nxt;
   logic [UW-1:0]         usedw_nxt, usedw_after_rd;
   logic [DATA_WIDTH-1:0] q_nxt;
   logic                  wr_acc, rd_acc;
   logic                  overflow_nxt, underflow_nxt;

   // Next-state computation; sclr overrides every request in its cycle.
   always_comb begin
      wr_acc         = wrreq & ~full;
      rd_acc         = rdreq & ~empty;
      wr_ptr_nxt     = wr_ptr;
      rd_ptr_nxt     = rd_ptr;
      usedw_nxt      = usedw;
      usedw_after_rd = usedw - UW'(rd_acc);
      q_nxt          = q;
      overflow_nxt   = overflow | (wrreq & full);
      underflow_nxt  = underflow | (rdreq & empty);

      if (wr_acc) wr_ptr_nxt = wr_ptr + PW'(1);
      if (rd_acc) rd_ptr_nxt = rd_ptr + PW'(1);

      if (wr_acc && !rd_acc)      usedw_nxt = usedw + UW'(1);
      else if (rd_acc && !wr_acc) usedw_nxt = usedw - UW'(1);

      if (SHOWAHEAD != 0) begin
         // New head is the incoming word only when nothing older survives this edge.
         if (usedw_nxt == '0)           q_nxt = '0;
         else if (usedw_after_rd == '0) q_nxt = data;
         else                           q_nxt = mem[rd_ptr_nxt];
      end else if (rd_acc) begin
         q_nxt = mem[rd_ptr];
      end

      if (sclr) begin
         wr_ptr_nxt    = '0;
         rd_ptr_nxt    = '0;
         usedw_nxt     = '0;
         q_nxt         = '0;
         overflow_nxt  = 1'b0;
         underflow_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         usedw        <= '0;
         q            <= '0;
         empty        <= 1'b1;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_nxt;
         rd_ptr       <= rd_ptr_nxt;
         usedw        <= usedw_nxt;
         q            <= q_nxt;
         empty        <= (usedw_nxt == '0);
         full         <= (usedw_nxt == UW'(DEPTH));
         almost_full  <= (usedw_nxt >= UW'(AF_LEVEL));
         almost_empty <= (usedw_nxt <= UW'(AE_LEVEL));
         overflow     <= overflow_nxt;
         underflow    <= underflow_nxt;
      end
   end

   // Storage array is intentionally left without reset.
   always_ff @(posedge clock) begin
      if (wr_acc && !sclr && !aclr) mem[wr_ptr] <= data;
   end

endmodule

// File: tb/tb_fifo_kband_sc.sv
// Directed bench for fifo_kband_sc: queue-based reference model checked every
// cycle on two instances (show-ahead default, and normal-mode 8x8).
module tb_fifo_kband_sc;

   logic       clock = 1'b0;
   logic       aclr, sclr;
   logic [2:0] da;
   logic       wr_a, rd_a;
   logic [7:0] db;
   logic       wr_b, rd_b;

   logic [2:0] q_a;
   logic       empty_a, full_a, af_a, ae_a, ov_a, uf_a;
   logic [4:0] usedw_a;
   logic [7:0] q_b;
   logic       empty_b, full_b, af_b, ae_b, ov_b, uf_b;
   logic [3:0] usedw_b;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   fifo_kband_sc u_a (
      .clock(clock), .aclr(aclr), .sclr(sclr), .data(da), .wrreq(wr_a), .rdreq(rd_a),
      .q(q_a), .empty(empty_a), .full(full_a), .usedw(usedw_a),
      .almost_full(af_a), .almost_empty(ae_a), .overflow(ov_a), .underflow(uf_a)
   );

   fifo_kband_sc #(.DATA_WIDTH(8), .DEPTH_LOG2(3), .SHOWAHEAD(0)) u_b (
      .clock(clock), .aclr(aclr), .sclr(sclr), .data(db), .wrreq(wr_b), .rdreq(rd_b),
      .q(q_b), .empty(empty_b), .full(full_b), .usedw(usedw_b),
      .almost_full(af_b), .almost_empty(ae_b), .overflow(ov_b), .underflow(uf_b)
   );

   // Reference model: plain queues plus sticky flags.
   logic [2:0] ma[$];
   logic [7:0] mb[$];
   logic [2:0] mqa = '0;
   logic [7:0] mqb = '0;
   bit ova = 0, ufa = 0, ovb = 0, ufb = 0;
   bit wacc, racc;

   always @(posedge clock or posedge aclr) begin
      if (aclr || sclr) begin
         ma.delete(); mb.delete();
         mqa = '0; mqb = '0;
         ova = 0; ufa = 0; ovb = 0; ufb = 0;
      end else begin
         wacc = (wr_a === 1'b1) && (ma.size() < 16);
         racc = (rd_a === 1'b1) && (ma.size() != 0);
         if (wr_a === 1'b1 && !wacc) ova = 1;
         if (rd_a === 1'b1 && !racc) ufa = 1;
         if (racc) void'(ma.pop_front());
         if (wacc) ma.push_back(da);
         mqa = (ma.size() != 0) ? ma[0] : 3'd0;

         wacc = (wr_b === 1'b1) && (mb.size() < 8);
         racc = (rd_b === 1'b1) && (mb.size() != 0);
         if (wr_b === 1'b1 && !wacc) ovb = 1;
         if (rd_b === 1'b1 && !racc) ufb = 1;
         if (racc) mqb = mb.pop_front();
         if (wacc) mb.push_back(db);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clock) begin
      if (chk_en) begin
         chk("a_q",     32'(q_a),     32'(mqa));
         chk("a_usedw", 32'(usedw_a), 32'(ma.size()));
         chk("a_empty", 32'(empty_a), 32'(ma.size() == 0));
         chk("a_full",  32'(full_a),  32'(ma.size() == 16));
         chk("a_af",    32'(af_a),    32'(ma.size() >= 14));
         chk("a_ae",    32'(ae_a),    32'(ma.size() <= 2));
         chk("a_ov",    32'(ov_a),    32'(ova));
         chk("a_uf",    32'(uf_a),    32'(ufa));
         chk("b_q",     32'(q_b),     32'(mqb));
         chk("b_usedw", 32'(usedw_b), 32'(mb.size()));
         chk("b_empty", 32'(empty_b), 32'(mb.size() == 0));
         chk("b_full",  32'(full_b),  32'(mb.size() == 8));
         chk("b_af",    32'(af_b),    32'(mb.size() >= 6));
         chk("b_ae",    32'(ae_b),    32'(mb.size() <= 2));
         chk("b_ov",    32'(ov_b),    32'(ovb));
         chk("b_uf",    32'(uf_b),    32'(ufb));
      end
   end

   task automatic op_a(input logic w, input logic r, input logic [2:0] d);
      @(negedge clock);
      wr_a = w; rd_a = r; da = d;
      @(posedge clock); #1;
      wr_a = 1'b0; rd_a = 1'b0;
   endtask

   task automatic op_b(input logic w, input logic r, input logic [7:0] d);
      @(negedge clock);
      wr_b = w; rd_b = r; db = d;
      @(posedge clock); #1;
      wr_b = 1'b0; rd_b = 1'b0;
   endtask

   task automatic flush(input logic w);
      @(negedge clock);
      sclr = 1'b1; wr_a = w; da = 3'd7;
      @(posedge clock); #1;
      sclr = 1'b0; wr_a = 1'b0;
   endtask

   initial begin
      aclr = 1'b1; sclr = 1'b0;
      wr_a = 1'b0; rd_a = 1'b0; da = '0;
      wr_b = 1'b0; rd_b = 1'b0; db = '0;
      repeat (2) @(posedge clock);
      #1 chk_en = 1'b1;
      chk("rst_usedw", 32'(usedw_a), 0);
      chk("rst_empty", 32'(empty_a), 1);
      chk("rst_ae",    32'(ae_a), 1);
      chk("rst_q",     32'(q_a), 0);
      @(negedge clock); aclr = 1'b0;

      // Underflow on empty, then 5 stored words
      op_a(0, 1, 0);
      chk("uf_set", 32'(uf_a), 1);
      for (int i = 1; i <= 5; i++) op_a(1, 0, 3'(i));
      chk("usedw5", 32'(usedw_a), 5);
      chk("head1",  32'(q_a), 1);

      // Asynchronous clear mid-cycle, with X requests while held
      #2 aclr = 1'b1;
      #1;
      chk("aclr_usedw", 32'(usedw_a), 0);
      chk("aclr_empty", 32'(empty_a), 1);
      chk("aclr_q",     32'(q_a), 0);
      chk("aclr_uf",    32'(uf_a), 0);
      chk("aclr_ov",    32'(ov_a), 0);
      wr_a = 1'bx; rd_a = 1'bx;
      @(posedge clock); #1;
      chk("aclr_x_usedw", 32'(usedw_a), 0);
      wr_a = 1'b0; rd_a = 1'b0;
      @(negedge clock); #2 aclr = 1'b0;
      op_a(1, 0, 3'b101);
      chk("post_aclr_usedw", 32'(usedw_a), 1);
      chk("post_aclr_q",     32'(q_a), 5);
      chk("post_aclr_empty", 32'(empty_a), 0);
      op_a(0, 1, 0);

      // Fill 0..7,0..7, overflow, drain in order
      for (int i = 0; i < 16; i++) begin
         op_a(1, 0, 3'(i));
         if (i == 12) chk("af_before14", 32'(af_a), 0);
         if (i == 13) chk("af_at14",     32'(af_a), 1);
      end
      chk("full16",  32'(full_a), 1);
      chk("usedw16", 32'(usedw_a), 16);
      op_a(1, 0, 3'd7);
      chk("ov_set",     32'(ov_a), 1);
      chk("usedw16_ov", 32'(usedw_a), 16);
      for (int i = 0; i < 16; i++) begin
         chk("drain_q", 32'(q_a), 32'(i % 8));
         op_a(0, 1, 0);
      end
      chk("drain_empty", 32'(empty_a), 1);
      chk("drain_usedw", 32'(usedw_a), 0);

      // Simultaneous requests at empty and at full
      flush(0);
      chk("flush_ov", 32'(ov_a), 0);
      op_a(1, 1, 3'd3);
      chk("sim_empty_usedw", 32'(usedw_a), 1);
      chk("sim_empty_uf",    32'(uf_a), 1);
      chk("sim_empty_empty", 32'(empty_a), 0);
      for (int i = 0; i < 15; i++) op_a(1, 0, 3'(i + 4));
      chk("sim_full_pre", 32'(full_a), 1);
      op_a(1, 1, 3'd6);
      chk("sim_full_usedw", 32'(usedw_a), 15);
      chk("sim_full_ov",    32'(ov_a), 1);
      chk("sim_full_head",  32'(q_a), 4);

      // Streaming at usedw=4 across three pointer wraps
      flush(0);
      for (int i = 0; i < 4; i++) op_a(1, 0, 3'(i));
      for (int i = 0; i < 48; i++) op_a(1, 1, 3'(i + 4));
      chk("stream_usedw", 32'(usedw_a), 4);
      chk("stream_head",  32'(q_a), 0);

      // Flush wins over a same-cycle write
      flush(0);
      for (int i = 0; i < 6; i++) op_a(1, 0, 3'(i));
      chk("usedw6", 32'(usedw_a), 6);
      flush(1);
      chk("sclr_usedw", 32'(usedw_a), 0);
      chk("sclr_empty", 32'(empty_a), 1);
      chk("sclr_ov",    32'(ov_a), 0);
      chk("sclr_q",     32'(q_a), 0);

      // Normal-mode instance
      op_b(1, 0, 8'hA1);
      op_b(1, 0, 8'hB2);
      chk("b_q_idle",  32'(q_b), 0);
      chk("b_usedw2",  32'(usedw_b), 2);
      op_b(0, 1, 0);
      chk("b_q_a1",    32'(q_b), 32'h A1);
      op_b(0, 0, 0);
      op_b(0, 0, 0);
      chk("b_q_hold",  32'(q_b), 32'h A1);
      op_b(0, 1, 0);
      chk("b_q_b2",    32'(q_b), 32'h B2);
      chk("b_empty",   32'(empty_b), 1);
      op_b(0, 1, 0);
      chk("b_q_keep",  32'(q_b), 32'h B2);
      chk("b_uf",      32'(uf_b), 1);

      @(negedge clock);
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
